// File: rtl/bsg_tag_unsync_sender.sv
// +--------------------------------------------------------------------------+
// | bsg_tag_unsync_sender: bsg_tag serial transmitter (reset, shift, no-op). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module bsg_tag_unsync_sender #(
  parameter int width_p        = 8,
  parameter int reset_cycles_p = 2,
  parameter int gap_cycles_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               reset_req_i,
  output logic               ready_o,
  output logic               op_o,
  output logic               param_o,
  output logic               done_o
);

  localparam int MAX_WR  = (width_p > reset_cycles_p) ? width_p : reset_cycles_p;
  localparam int MAX_LEN = (MAX_WR > gap_cycles_p) ? MAX_WR : gap_cycles_p;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t SHIFT_LAST = cnt_t'(width_p - 1);
  localparam cnt_t RESET_LAST = cnt_t'((reset_cycles_p > 0) ? reset_cycles_p - 1 : 0);
  localparam cnt_t GAP_LAST   = cnt_t'(gap_cycles_p - 1);
  localparam logic RESET_EN   = (reset_cycles_p > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [width_p-1:0] shift_q, shift_d;
  logic               flag_q,  flag_d;
  cnt_t               cnt_q,   cnt_d;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  // Each phase starts its counter at zero and exits on its last index.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (v_i) begin
          shift_d = data_i;
          flag_d  = reset_req_i;
          cnt_d   = '0;
          state_d = (reset_req_i && RESET_EN) ? RESET : SHIFT;
        end
      end
      RESET: begin
        if (!flag_q || (cnt_q == RESET_LAST)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      SHIFT: begin
        shift_d = shift_q >> 1;
        if (cnt_q == SHIFT_LAST) begin
          state_d = GAP;
          flag_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode flops only, so reset forces a no-op immediately.
  assign ready_o = (state_q == IDLE);
  assign op_o    = (state_q == SHIFT);
  assign param_o = (state_q == RESET) | ((state_q == SHIFT) & shift_q[0]);
  assign done_o  = (state_q == GAP) & (cnt_q == GAP_LAST);

endmodule

`default_nettype wire

// File: tb/tb_bsg_tag_unsync_sender.sv
// +--------------------------------------------------------------------------+
// | tb_bsg_tag_unsync_sender: scoreboard bench with client models.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_bsg_tag_unsync_sender;

  typedef struct {
    logic       op;
    logic       param;
    logic       done;
    logic       ready;
    logic       chk;
    logic [7:0] word;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       v_a = 1'b0;
  logic       v_b = 1'b0;
  logic [7:0] data = 8'h00;
  logic       rreq = 1'b0;

  logic ready_a, op_a, par_a, done_a;
  logic ready_b, op_b, par_b, done_b;

  int vectors = 0;
  int miscompares = 0;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  bsg_tag_unsync_sender #(.width_p(8), .reset_cycles_p(3), .gap_cycles_p(2)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_a), .data_i(data), .reset_req_i(rreq),
    .ready_o(ready_a), .op_o(op_a), .param_o(par_a), .done_o(done_a)
  );

  bsg_tag_unsync_sender #(.width_p(8), .reset_cycles_p(0), .gap_cycles_p(2)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_b), .data_i(data), .reset_req_i(rreq),
    .ready_o(ready_b), .op_o(op_b), .param_o(par_b), .done_o(done_b)
  );

  // Unsync tag clients: op/param register, then data shifted in at the MSB.
  logic       cop_a = 1'b0, cpar_a = 1'b0, cop_b = 1'b0, cpar_b = 1'b0;
  logic [7:0] cl_a = 8'h00, cl_b = 8'h00;

  always_ff @(posedge clk) begin
    cop_a  <= op_a;
    cpar_a <= par_a;
    cop_b  <= op_b;
    cpar_b <= par_b;
    if (cop_a) cl_a <= {cpar_a, cl_a[7:1]};
    if (cop_b) cl_b <= {cpar_b, cl_b[7:1]};
  end

  function automatic exp_t mk(input logic op, input logic param, input logic done,
                              input logic ready, input logic chk, input logic [7:0] word);
    exp_t e;
    e.op = op; e.param = param; e.done = done; e.ready = ready; e.chk = chk; e.word = word;
    return e;
  endfunction

  task automatic push_item(input int which, input exp_t e);
    if (which == 0) qa.push_back(e);
    else            qb.push_back(e);
  endtask

  // Expected per-cycle outputs from the cycle after acceptance onward.
  task automatic push_txn(input int which, input logic [7:0] d, input logic rr, input int rc);
    if (rr) for (int i = 0; i < rc; i++) push_item(which, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
    for (int i = 0; i < 8; i++) push_item(which, mk(1'b1, d[i], 1'b0, 1'b0, 1'b0, 8'h00));
    push_item(which, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    push_item(which, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, d));
    push_item(which, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
  endtask

  task automatic check_dut(input int which);
    exp_t       e;
    logic [3:0] obs, expv;
    logic [7:0] cl;
    e = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    if (which == 0) begin
      if (qa.size() > 0) e = qa.pop_front();
      obs = {op_a, par_a, done_a, ready_a};
      cl  = cl_a;
    end else begin
      if (qb.size() > 0) e = qb.pop_front();
      obs = {op_b, par_b, done_b, ready_b};
      cl  = cl_b;
    end
    expv = {e.op, e.param, e.done, e.ready};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL dut%0d_outputs t=%0t {op,param,done,ready} observed %b expected %b",
             which, $time, obs, expv);
    end
    if (e.chk) begin
      vectors++;
      assert (cl === e.word) else begin
        miscompares++;
        $error("FAIL dut%0d_client t=%0t observed %h expected %h", which, $time, cl, e.word);
      end
    end
  endtask

  // One clock: drive at negedge, predict acceptance, compare after the edge.
  task automatic tick(input logic va, input logic vb, input logic [7:0] d, input logic rr);
    @(negedge clk);
    v_a = va; v_b = vb; data = d; rreq = rr;
    if (va && qa.size() == 0) push_txn(0, d, rr, 3);
    if (vb && qb.size() == 0) push_txn(1, d, rr, 0);
    @(posedge clk);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < 200) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0);
      n++;
    end
    vectors++;
    assert (n < 200) else begin
      miscompares++;
      $error("FAIL drain_timeout observed %0d cycles expected below 200", n);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    assert ({op_a, par_a, done_a, op_b, par_b, done_b} === 6'b0) else begin
      miscompares++;
      $error("FAIL reset_outputs observed %b expected %b",
             {op_a, par_a, done_a, op_b, par_b, done_b}, 6'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick(1'b0, 1'b0, 8'h00, 1'b0);

    // Plain 8'hA5, no reset phase
    tick(1'b1, 1'b0, 8'hA5, 1'b0);
    drain();

    // Reset phase of 3 cycles, then 8'h01
    tick(1'b1, 1'b0, 8'h01, 1'b1);
    drain();

    // Back-to-back FF then 00 with valid held high
    tick(1'b1, 1'b0, 8'hFF, 1'b0);
    for (int i = 0; i < 11; i++) tick(1'b1, 1'b0, 8'h00, 1'b0);
    drain();

    // Request while busy is ignored
    tick(1'b1, 1'b0, 8'h96, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 8'h3C, 1'b1);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    drain();

    // Asynchronous reset in the middle of a shift
    tick(1'b1, 1'b0, 8'hC3, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    qa.delete();
    vectors++;
    assert ({op_a, par_a, done_a, ready_a} === 4'b0001) else begin
      miscompares++;
      $error("FAIL async_reset {op,param,done,ready} observed %b expected %b",
             {op_a, par_a, done_a, ready_a}, 4'b0001);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 8'h5A, 1'b0);
    drain();

    // Zero-length reset phase requested on the second instance
    tick(1'b0, 1'b1, 8'h6E, 1'b1);
    drain();
    tick(1'b0, 1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bsg_tag_unsync_sender.md
Name: bsg_tag_unsync_sender

Overview:
Transmit end of the bsg_tag serial config protocol for an unsynchronized tag client on the same clock. Accepts a parallel word via valid/ready, optionally drives a reset op, shifts the word out LSB-first as shift ops, then trails with no-ops. Lives in on-chip config/boot logic wherever a block must preload an unsync tag client before its own reset deasserts.

Parameters:
width_p, "inv", payload width; must equal the target client's width_p; >=1.
reset_cycles_p, 2, cycles of reset op (op=0,param=1) emitted when reset_req_i is set; 0 disables reset phase.
gap_cycles_p, 2, trailing no-op cycles (op=0,param=0) after the last shift bit; >=1.

Ports:
clk_i  in  1  clock; also the tag clock of the driven client.
reset_n_i  in  1  asynchronous, active-low reset.
v_i  in  1  request valid.
data_i  in  width_p  word to load into the client.
reset_req_i  in  1  emit reset phase before shifting; sampled with data_i.
ready_o  out  1  sender idle and able to accept a request.
op_o  out  1  tag op bit to the client.
param_o  out  1  tag param bit to the client.
done_o  out  1  one-cycle pulse in the last gap cycle of a transaction.

Behaviour:
- Encoding on (op_o,param_o): (1,b) shift b into client MSB; (0,1) reset op; (0,0) no-op. Never drive any other meaning.
- State machine IDLE, RESET, SHIFT, GAP; state, shift reg, flag and counter all flopped, async-cleared.
- op_o = (state==SHIFT); param_o = (state==RESET) | (state==SHIFT & shift_r[0]). Pure decode of flops, no dependence on inputs.
- ready_o = (state==IDLE). While reset_n_i low: state=IDLE, shift_r=0, count=0, op_o=0, param_o=0, done_o=0. ready_o=1 from the first cycle after deassertion.
- IDLE: on v_i & ready_o at edge T, latch data_i into shift_r and reset_req_i into the flag. Next state RESET if reset_req_i & reset_cycles_p>0, else SHIFT. v_i while not ready is ignored; data_i/reset_req_i are not sampled.
- RESET: hold reset_cycles_p cycles, then SHIFT.
- SHIFT: exactly width_p cycles. Each cycle presents shift_r[0], then shifts shift_r right with zero fill. First bit sent is data_i[0]. After width_p shifts, client register equals data_i.
- GAP: gap_cycles_p cycles of no-op. done_o=1 only in the final GAP cycle. Then IDLE, so ready_o=1 the next cycle.
- Latency without reset phase: first shift bit at T+1, last at T+width_p, done_o at T+width_p+gap_cycles_p, ready_o at T+width_p+gap_cycles_p+1.
- With reset phase, every figure after T shifts by +reset_cycles_p.
- Client data_async_r_o holds the final value 2 cycles after the last shift cycle (client op/param register, then data register). gap_cycles_p>=2 guarantees done_o is no earlier than that.
- Counter width: $clog2(max(width_p,reset_cycles_p,gap_cycles_p)+1). Reload at each phase entry; terminal count is phase length minus 1.
- Back-to-back: a new request is accepted only in IDLE, so at least one idle no-op cycle separates transactions.
- Reset mid-transaction: outputs go to no-op immediately (async). The client's partially shifted contents are undefined; the user must resend.
- width_p=1: one SHIFT cycle.

Test Plan:
- width_p=8, gap=2, data_i=8'hA5, reset_req_i=0, accept at T -> (op,param) T+1..T+8 = (1,1),(1,0),(1,1),(1,0),(1,0),(1,1),(1,0),(1,1); no-ops T+9,T+10; done_o at T+10; ready_o at T+11; attached client reads 8'hA5 at T+10.
- reset_req_i=1, reset_cycles_p=3, data_i=8'h01 -> (0,1) at T+1..T+3; shifts T+4..T+11 with param=1 only at T+4; done_o at T+13.
- Back-to-back 8'hFF then 8'h00 with v_i held high -> second accepted at T+11; client transitions FF->00; no shift cycle is lost or duplicated.
- v_i pulsed while busy with data_i=8'h3C -> ignored; client still ends with the first word.
- reset_n_i asserted low at T+4 of an 8-bit shift -> op_o=param_o=0 the same cycle; ready_o=1 after release; new request 8'h5A loads correctly.
- reset_cycles_p=0 with reset_req_i=1 -> no (0,1) cycles; shifting starts at T+1.
